if_id_decode_stage: RTL and testbench
=====================================

// Module: if_id_decode_stage
// PURPOSE
//  Registered IF->ID pipeline stage with a built-in RV32I field decoder and immediate generator.
//  Accepts a fetched instruction and PC over a valid/ready handshake and buffers them in a 2-entry skid buffer.
//  Presents decoded fields, a sign-extended immediate and the format class to EX one cycle later.
//  Supports back-pressure (stall) and flush on a taken branch or jump.
// PARAMETERS
//  XLEN  32  datapath width of PC and immediate (32 or 64); immediates sign-extend to XLEN
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous, active-high reset
//  flush      in   1     discard all buffered entries; synchronous to clk
//  in_valid   in   1     IF presents instruction
//  in_ready   out  1     stage can accept; registered, equals !skid_valid
//  in_instr   in   32    raw instruction word
//  in_pc      in   XLEN  PC of in_instr
//  out_valid  out  1     decoded entry valid
//  out_ready  in   1     ID/EX consumes entry
//  out_pc     out  XLEN  PC of presented entry
//  op         out  7     opcode
//  rd         out  5     destination register (0 for S/B)
//  funct3     out  3     funct3 (0 for U/J)
//  rs1        out  5     source 1 (0 for U/J)
//  rs2        out  5     source 2 (R/S/B only, else 0)
//  funct7     out  7     funct7 (R only, else 0)
//  imm        out  XLEN  sign-extended immediate, LSB-aligned per format
//  fmt        out  3     format: 0=R 1=I 2=S 3=B 4=U 5=J 7=NONE
//  illegal    out  1     opcode not in supported set (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, all decoded outputs and out_pc=0, fmt=NONE, illegal=0; buffer state=EMPTY.
//  - Decode runs combinationally on in_instr and is registered with the entry; latency from accept to out_valid=1 is 1 cycle.
//  - Accept = in_valid & in_ready. Consume = out_valid & out_ready.
//  - States: EMPTY (main invalid), ONE (main valid), TWO (main + skid valid).
//  - EMPTY: accept -> ONE.
//  - ONE: accept & consume -> ONE (main reloads). Accept only -> TWO (new entry goes to skid). Consume only -> EMPTY.
//  - TWO: in_ready=0. Consume -> ONE (skid moves to main). Otherwise hold.
//  - Outputs are always driven from main; skid never bypasses main (strict order).
//  - flush (highest priority): next state=EMPTY; any accept in the same cycle is dropped; out_valid=0 next cycle; in_ready=1 next cycle.
//  - Immediates: I={{XLEN-12{i[31]}},i[31:20]}. S=sext{i[31:25],i[11:7]}. B=sext{i[31],i[7],i[30:25],i[11:8],1'b0}.
//    J=sext{i[31],i[19:12],i[20],i[30:21],1'b0}. U=sext{i[31:12],12'b0}. R and NONE: imm=0.
//  - Opcode map: R=0110011; I=0010011, 0000011, 1100111, 1110011 (SYSTEM); S=0100011; B=1100011; U=0110111, 0010111; J=1101111.
//  - Unsupported opcode: all fields 0, fmt=NONE; the entry still flows through the handshake.
//  - Asserting rst mid-transfer discards all entries immediately.
// CONFIGURATION
//  ILLEGAL_DETECT_EN defined: illegal=1 for an unsupported opcode or instr[1:0]!=2'b11; op still carries instr[6:0].
//  Not defined: illegal is tied to 0 and op=0 for unsupported opcodes.
// STRUCTURE
//  - Package rv_isa_pkg: opcode localparams, fmt encodings, XLEN-agnostic immediate-extraction functions.
//  - Sub-module rv_decode_comb: purely combinational instr -> {op, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal}.
//  - Top level holds the 2-entry buffer and the handshake FSM.
// TESTING
//  - addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF.
//  - sw x2,8(x1) (0x0020A423) -> fmt=2, rs1=1, rs2=2, rd=0, imm=8.
//  - beq x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC. lui x5,0x12345 (0x123452B7) -> fmt=4, rd=5, imm=0x12345000.
//  - out_ready=0 with 3 back-to-back in_valid -> 2 accepted, in_ready=0 after the 2nd.
//    Release out_ready -> entries drain in order, and in_ready returns 1 the cycle after the first consume.
//  - State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed entries never appear.
//  - instr 0x0000007F: ILLEGAL_DETECT_EN gives illegal=1, fmt=7; without it, illegal=0, op=0.
//    XLEN=64: addi -1 gives imm=0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I opcode map, format encodings, decoded-field record and immediate extractors.
// Immediates come back sign-extended to 64 bits so callers can slice any XLEN up to 64.
package rv_isa_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_t;

    localparam dec_t DEC_NONE = '{op: 7'd0, rd: 5'd0, funct3: 3'd0, rs1: 5'd0, rs2: 5'd0,
                                  funct7: 7'd0, fmt: FMT_NONE, illegal: 1'b0};

    function automatic fmt_e opc_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP:                                    return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return FMT_I;
            OPC_STORE:                                 return FMT_S;
            OPC_BRANCH:                                return FMT_B;
            OPC_LUI, OPC_AUIPC:                        return FMT_U;
            OPC_JAL:                                   return FMT_J;
            default:                                   return FMT_NONE;
        endcase
    endfunction

    function automatic logic [63:0] imm_i(input logic [31:0] i);
        return {{52{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] i);
        return {{52{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] imm_u(input logic [31:0] i);
        return {{32{i[31]}}, i[31:12], 12'd0};
    endfunction

    function automatic logic [63:0] imm_j(input logic [31:0] i);
        return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I field decoder and immediate generator.
// ILLEGAL_DETECT_EN: flag unsupported opcodes and keep their raw opcode on op.
module rv_decode_comb
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output dec_t            dec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [63:0] imm_full;
    fmt_e        fmt;

    // Fields outside a format stay zero so EX never sees stale register indices.
    always_comb begin
        fmt      = opc_fmt(instr_i[6:0]);
        dec_o    = DEC_NONE;
        imm_full = 64'd0;
        case (fmt)
            FMT_R: begin
                dec_o.op     = instr_i[6:0];
                dec_o.rd     = instr_i[11:7];
                dec_o.funct3 = instr_i[14:12];
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.funct7 = instr_i[31:25];
                dec_o.fmt    = FMT_R;
            end
            FMT_I: begin
                dec_o.op     = instr_i[6:0];
                dec_o.rd     = instr_i[11:7];
                dec_o.funct3 = instr_i[14:12];
                dec_o.rs1    = instr_i[19:15];
                dec_o.fmt    = FMT_I;
                imm_full     = imm_i(instr_i);
            end
            FMT_S, FMT_B: begin
                dec_o.op     = instr_i[6:0];
                dec_o.funct3 = instr_i[14:12];
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.fmt    = fmt;
                imm_full     = (fmt == FMT_S) ? imm_s(instr_i) : imm_b(instr_i);
            end
            FMT_U: begin
                dec_o.op  = instr_i[6:0];
                dec_o.rd  = instr_i[11:7];
                dec_o.fmt = FMT_U;
                imm_full  = imm_u(instr_i);
            end
            FMT_J: begin
                dec_o.op  = instr_i[6:0];
                dec_o.rd  = instr_i[11:7];
                dec_o.fmt = FMT_J;
                imm_full  = imm_j(instr_i);
            end
            default: begin
`ifdef ILLEGAL_DETECT_EN
                // Every supported opcode ends in 2'b11, so a bad length field lands here too.
                dec_o.op      = instr_i[6:0];
                dec_o.illegal = 1'b1;
`endif
            end
        endcase
        imm_o = imm_full[XLEN-1:0];
    end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF->ID stage: 2-entry skid buffer (main + skid) with registered decode and flush.
// ILLEGAL_DETECT_EN enables illegal-opcode reporting in the decoder.
module if_id_decode_stage
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      op,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_t            dec;
    } entry_t;

    localparam entry_t ENTRY_RST = '{pc: '0, imm: '0, dec: DEC_NONE};

    buf_state_e      state_q;
    entry_t          main_q, skid_q, new_entry;
    logic            out_valid_q, in_ready_q;
    logic            accept, consume;
    dec_t            dec_new;
    logic [XLEN-1:0] imm_new;

    rv_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr_i (in_instr),
        .dec_o   (dec_new),
        .imm_o   (imm_new)
    );

    assign new_entry = '{pc: in_pc, imm: imm_new, dec: dec_new};
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid_q & out_ready;

    // in_ready/out_valid are registered alongside the state so both are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= ENTRY_RST;
            skid_q      <= ENTRY_RST;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= new_entry;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        skid_q     <= new_entry;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (consume) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_q.pc;
    assign op        = main_q.dec.op;
    assign rd        = main_q.dec.rd;
    assign funct3    = main_q.dec.funct3;
    assign rs1       = main_q.dec.rs1;
    assign rs2       = main_q.dec.rs2;
    assign funct7    = main_q.dec.funct7;
    assign imm       = main_q.imm;
    assign fmt       = main_q.dec.fmt;
    assign illegal   = main_q.dec.illegal;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Table-driven decode vectors with an in-order scoreboard, plus back-pressure, flush and reset sequences.
module tb_if_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm;
    logic [6:0]  op, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, fmt;

    logic [63:0] in_pc64, out_pc64, imm64;
    logic        in_ready64, out_valid64, illegal64;
    logic [6:0]  op64, funct7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  funct3_64, fmt64;

    always #5 clk = ~clk;
    assign in_pc64 = {32'd0, in_pc};

    if_id_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .op(op), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
    );

    if_id_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(out_pc64), .op(op64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
        .funct7(funct7_64), .imm(imm64), .fmt(fmt64), .illegal(illegal64)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    vec_t        vecs[14];
    exp_t        sb[$];
    exp_t        cur_exp;
    logic [31:0] pc_ctr;
    int          tests = 0;
    int          fails = 0;

    function automatic exp_t mk(input logic [6:0] op_, input logic [4:0] rd_, input logic [2:0] f3_,
                                input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [6:0] f7_,
                                input logic [31:0] imm_, input logic [2:0] fmt_, input logic ill_);
        return '{pc: 32'd0, op: op_, rd: rd_, f3: f3_, rs1: rs1_, rs2: rs2_, f7: f7_,
                 imm: imm_, fmt: fmt_, ill: ill_};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Negedge snapshot: consume pops the scoreboard, accept pushes, flush/reset empty it.
    task automatic sample();
        exp_t got;
        got = '{pc: out_pc, op: op, rd: rd, f3: funct3, rs1: rs1, rs2: rs2, f7: funct7,
                imm: imm, fmt: fmt, ill: illegal};
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h with nothing outstanding", got);
                end else begin
                    check("entry", 128'(got), 128'(sb.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                cur_exp.pc = in_pc;
                sb.push_back(cur_exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_ctr;
        cur_exp  = e;
        for (int k = 0; k < 50 && !done; k++) begin
            if (!in_ready) out_ready = 1'b1;
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: instr %h never accepted", instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hFFF00093, mk(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF, 3'd1, 1'b0)};
        vecs[1]  = '{32'h0020A423, mk(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h00000008, 3'd2, 1'b0)};
        vecs[2]  = '{32'hFE000EE3, mk(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC, 3'd3, 1'b0)};
        vecs[3]  = '{32'h123452B7, mk(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 3'd4, 1'b0)};
        vecs[4]  = '{32'h402081B3, mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h00000000, 3'd0, 1'b0)};
        vecs[5]  = '{32'h008000EF, mk(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000008, 3'd5, 1'b0)};
        vecs[6]  = '{32'hFF9FF06F, mk(7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFF8, 3'd5, 1'b0)};
        vecs[8]  = '{32'hFFC12303, mk(7'h03, 5'd6, 3'd2, 5'd2, 5'd0, 7'h00, 32'hFFFFFFFC, 3'd1, 1'b0)};
        vecs[9]  = '{32'h80000397, mk(7'h17, 5'd7, 3'd0, 5'd0, 5'd0, 7'h00, 32'h80000000, 3'd4, 1'b0)};
        vecs[10] = '{32'h00000073, mk(7'h73, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd1, 1'b0)};
        vecs[12] = '{32'hFE530FA3, mk(7'h23, 5'd0, 3'd0, 5'd6, 5'd5, 7'h00, 32'hFFFFFFFF, 3'd2, 1'b0)};
        vecs[13] = '{32'h00008067, mk(7'h67, 5'd0, 3'd0, 5'd1, 5'd0, 7'h00, 32'h00000000, 3'd1, 1'b0)};
`ifdef ILLEGAL_DETECT_EN
        vecs[7]  = '{32'h0000007F, mk(7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b1)};
        vecs[11] = '{32'h00000010, mk(7'h10, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b1)};
`else
        vecs[7]  = '{32'h0000007F, mk(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b0)};
        vecs[11] = '{32'h00000010, mk(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b0)};
`endif

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; pc_ctr = 32'h0000_1000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(1'b1));
        check("rst_out_pc",    128'(out_pc),    128'(32'd0));
        check("rst_fmt",       128'(fmt),       128'(3'd7));
        check("rst_illegal",   128'(illegal),   128'(1'b0));
        check("rst_fields",    128'({op, rd, funct3, rs1, rs2, funct7, imm}), 128'(64'd0));
        rst = 1'b0;
        tick();

        // Pass 1: free-flowing, one entry per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].instr, vecs[i].e);
            if (i == 0) begin
                check("latency_valid", 128'(out_valid), 128'(1'b1));
                check("xlen64_imm",    128'(imm64),     128'(64'hFFFF_FFFF_FFFF_FFFF));
            end
        end

        // Pass 2: random back-pressure from EX.
        for (int i = 0; i < 14; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(vecs[13 - i].instr, vecs[13 - i].e);
        end
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain_empty", 128'(sb.size()), 128'(0));

        // Back-pressure: two accepted, third held off.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = vecs[1].instr; cur_exp = vecs[1].e; in_pc = 32'h2000;
        tick();
        check("bp_ready_after1", 128'(in_ready), 128'(1'b1));
        in_instr = vecs[2].instr; cur_exp = vecs[2].e; in_pc = 32'h2004;
        tick();
        check("bp_ready_after2", 128'(in_ready), 128'(1'b0));
        in_instr = vecs[3].instr; cur_exp = vecs[3].e; in_pc = 32'h2008;
        tick();
        check("bp_ready_hold", 128'(in_ready), 128'(1'b0));
        check("bp_head_pc",    128'(out_pc),   128'(32'h2000));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_ready_return", 128'(in_ready),  128'(1'b1));
        check("bp_second_valid", 128'(out_valid), 128'(1'b1));
        check("bp_second_pc",    128'(out_pc),    128'(32'h2004));
        tick();
        check("bp_drained", 128'(out_valid), 128'(1'b0));
        check("bp_sb_empty", 128'(sb.size()), 128'(0));

        // Flush from TWO with a simultaneous valid input.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = vecs[4].instr; cur_exp = vecs[4].e; in_pc = 32'h3000;
        tick();
        in_instr = vecs[5].instr; cur_exp = vecs[5].e; in_pc = 32'h3004;
        tick();
        check("fl_pre_ready", 128'(in_ready), 128'(1'b0));
        flush = 1'b1;
        in_instr = vecs[6].instr; cur_exp = vecs[6].e; in_pc = 32'h3008;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 128'(out_valid), 128'(1'b0));
        check("fl_in_ready",  128'(in_ready),  128'(1'b1));
        out_ready = 1'b1;
        repeat (3) tick();
        check("fl_stays_empty", 128'(out_valid), 128'(1'b0));
        send(vecs[3].instr, vecs[3].e);
        tick();

        // Asynchronous reset with an entry held in main.
        out_ready = 1'b0;
        send(vecs[0].instr, vecs[0].e);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(1'b0));
        check("arst_in_ready",  128'(in_ready),  128'(1'b1));
        check("arst_fmt",       128'(fmt),       128'(3'd7));
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(vecs[12].instr, vecs[12].e);
        repeat (3) tick();
        check("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
